serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor. Computes diff = a - b - bin, LSB first, one bit per clock.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// The master drives the request and operands; the slave returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single
// full-subtractor cell whose borrow is carried between bits in a flip-flop.
module fullsubtractor1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_bout
);
  assign o_diff = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_brw;
  logic             r_signA;
  logic             r_signB;
  logic             r_bout;
  logic             r_ovf;
  logic [WIDTH-1:0] w_resNext;
  logic             w_cellDiff;
  logic             w_cellBout;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

  fullsubtractor1 u_cell (
    .i_a    (r_aSh[0]),
    .i_b    (r_bSh[0]),
    .i_bin  (r_brw),
    .o_diff (w_cellDiff),
    .o_bout (w_cellBout)
  );

  // r_res only keeps the upper WIDTH-1 partial bits; the final bit goes
  // straight from the cell into r_diff on the last shift edge.
  assign w_resNext = {w_cellDiff, r_res};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_brw   <= 1'b0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_aSh   <= bus.a;
        r_bSh   <= bus.b;
        r_brw   <= bus.bin;
        r_signA <= bus.a[WIDTH-1];
        r_signB <= bus.b[WIDTH-1];
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_res <= w_resNext[WIDTH-1:1];
        r_brw <= w_cellBout;
        r_aSh <= r_aSh >> 1;
        r_bSh <= r_bSh >> 1;
        r_cnt <= r_cnt + CNT_W'(1);
        // Visible results change only here, so they hold through later shifts.
        if (w_last) begin
          r_diff <= w_resNext;
          r_bout <= w_cellBout;
          r_ovf  <= (r_signA != r_signB) && (w_resNext[WIDTH-1] != r_signA);
        end
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit scenarios plus an exhaustive
// 4-bit sweep against an arithmetic reference.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFails = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one op and returns at the cycle done is high; lat counts edges after accept.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, output int lat);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
    tick();
    bus8.start = 1'b0;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin, output int lat);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.bin = bin;
    tick();
    bus4.start = 1'b0;
    lat = 0;
    while (bus4.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    nChecks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_status: busy=%b done=%b expected 0 0", bus8.busy, bus8.done);
    end
    nChecks++;
    if (bus8.diff !== 8'h00 || bus8.bout !== 1'b0 || bus8.ovf !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_result: diff=%h bout=%b ovf=%b expected 00 0 0", bus8.diff, bus8.bout, bus8.ovf);
    end
    nChecks++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.diff !== 4'h0) begin
      nFails++; $display("[TB] FAIL reset_w4: busy=%b done=%b diff=%h expected 0 0 0", bus4.busy, bus4.done, bus4.diff);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    run8(8'h05, 8'h03, 1'b0, lat);
    nChecks++;
    if (lat !== 8) begin
      nFails++; $display("[TB] FAIL basic_latency: got %0d edges expected 8", lat);
    end
    nChecks++;
    if (bus8.diff !== 8'h02 || bus8.bout !== 1'b0 || bus8.ovf !== 1'b0) begin
      nFails++; $display("[TB] FAIL basic_result: diff=%h bout=%b ovf=%b expected 02 0 0", bus8.diff, bus8.bout, bus8.ovf);
    end
    nChecks++;
    if (bus8.busy !== 1'b1) begin
      nFails++; $display("[TB] FAIL basic_busy_in_done: got %b expected 1", bus8.busy);
    end
    tick();
    nChecks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
      nFails++; $display("[TB] FAIL basic_after_done: done=%b busy=%b expected 0 0", bus8.done, bus8.busy);
    end
  endtask

  task automatic test_borrow();
    int lat;
    run8(8'h03, 8'h05, 1'b0, lat);
    nChecks++;
    if (lat !== 8 || bus8.diff !== 8'hFE || bus8.bout !== 1'b1 || bus8.ovf !== 1'b0) begin
      nFails++; $display("[TB] FAIL borrow_neg: lat=%0d diff=%h bout=%b ovf=%b expected 8 FE 1 0", lat, bus8.diff, bus8.bout, bus8.ovf);
    end
    tick();
    run8(8'h00, 8'h00, 1'b1, lat);
    nChecks++;
    if (lat !== 8 || bus8.diff !== 8'hFF || bus8.bout !== 1'b1 || bus8.ovf !== 1'b0) begin
      nFails++; $display("[TB] FAIL borrow_ripple: lat=%0d diff=%h bout=%b ovf=%b expected 8 FF 1 0", lat, bus8.diff, bus8.bout, bus8.ovf);
    end
    tick();
  endtask

  task automatic test_overflow();
    int lat;
    run8(8'h80, 8'h01, 1'b0, lat);
    nChecks++;
    if (lat !== 8 || bus8.diff !== 8'h7F || bus8.bout !== 1'b0 || bus8.ovf !== 1'b1) begin
      nFails++; $display("[TB] FAIL ovf_neg_minus_pos: lat=%0d diff=%h bout=%b ovf=%b expected 8 7F 0 1", lat, bus8.diff, bus8.bout, bus8.ovf);
    end
    tick();
    run8(8'h7F, 8'hFF, 1'b0, lat);
    nChecks++;
    if (lat !== 8 || bus8.diff !== 8'h80 || bus8.bout !== 1'b1 || bus8.ovf !== 1'b1) begin
      nFails++; $display("[TB] FAIL ovf_pos_minus_neg: lat=%0d diff=%h bout=%b ovf=%b expected 8 80 1 1", lat, bus8.diff, bus8.bout, bus8.ovf);
    end
    tick();
  endtask

  task automatic test_ignore_and_reset();
    int  lat;
    logic sawDone;
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    nChecks++;
    if (bus8.busy !== 1'b1 || bus8.diff !== 8'h80 || bus8.ovf !== 1'b1) begin
      nFails++; $display("[TB] FAIL hold_during_shift: busy=%b diff=%h ovf=%b expected 1 80 1", bus8.busy, bus8.diff, bus8.ovf);
    end
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00;
    tick();
    bus8.start = 1'b0;
    lat = 3;
    while (bus8.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    nChecks++;
    if (lat !== 8 || bus8.diff !== 8'h0F || bus8.bout !== 1'b0 || bus8.ovf !== 1'b0) begin
      nFails++; $display("[TB] FAIL ignore_start: lat=%0d diff=%h bout=%b ovf=%b expected 8 0F 0 0", lat, bus8.diff, bus8.bout, bus8.ovf);
    end
    tick();
    nChecks++;
    if (bus8.busy !== 1'b0) begin
      nFails++; $display("[TB] FAIL ignore_no_requeue: busy=%b expected 0", bus8.busy);
    end
    bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h11;
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nChecks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.bout !== 1'b0 || bus8.ovf !== 1'b0) begin
      nFails++; $display("[TB] FAIL midop_reset: busy=%b done=%b diff=%h bout=%b ovf=%b expected 0 0 00 0 0", bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf);
    end
    sawDone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) sawDone = 1'b1;
    end
    nChecks++;
    if (sawDone !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_aborts_op: activity=%b expected 0", sawDone);
    end
    run8(8'h20, 8'h01, 1'b1, lat);
    nChecks++;
    if (lat !== 8 || bus8.diff !== 8'h1E || bus8.bout !== 1'b0 || bus8.ovf !== 1'b0) begin
      nFails++; $display("[TB] FAIL after_reset_op: lat=%0d diff=%h bout=%b ovf=%b expected 8 1E 0 0", lat, bus8.diff, bus8.bout, bus8.ovf);
    end
    tick();
  endtask

  // With start held high, each op costs accept + WIDTH shifts + DONE + IDLE,
  // so done pulses land WIDTH+2 edges apart.
  task automatic test_back_to_back();
    logic [7:0] opA [3]   = '{8'h64, 8'h01, 8'h40};
    logic [7:0] opB [3]   = '{8'h32, 8'h02, 8'hC0};
    logic       opBin [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] expD [3]  = '{8'h32, 8'hFE, 8'h80};
    logic       expB [3]  = '{1'b0, 1'b1, 1'b1};
    logic       expO [3]  = '{1'b0, 1'b0, 1'b1};
    int doneAt [3];
    int cyc;
    bus8.start = 1'b1; bus8.a = opA[0]; bus8.b = opB[0]; bus8.bin = opBin[0];
    tick();
    cyc = 0;
    bus8.a = opA[1]; bus8.b = opB[1]; bus8.bin = opBin[1];
    for (int i = 0; i < 3; i++) begin
      while (bus8.done !== 1'b1 && cyc < 200) begin
        tick();
        cyc++;
      end
      doneAt[i] = cyc;
      nChecks++;
      if (bus8.diff !== expD[i] || bus8.bout !== expB[i] || bus8.ovf !== expO[i]) begin
        nFails++; $display("[TB] FAIL b2b_result%0d: diff=%h bout=%b ovf=%b expected %h %b %b", i, bus8.diff, bus8.bout, bus8.ovf, expD[i], expB[i], expO[i]);
      end
      if (i < 2) begin
        bus8.a = opA[i+1]; bus8.b = opB[i+1]; bus8.bin = opBin[i+1];
      end else begin
        bus8.start = 1'b0;
      end
      tick();
      cyc++;
    end
    nChecks++;
    if (doneAt[0] !== 8 || doneAt[1] - doneAt[0] !== 10 || doneAt[2] - doneAt[1] !== 10) begin
      nFails++; $display("[TB] FAIL b2b_spacing: done at %0d,%0d,%0d expected 8,18,28", doneAt[0], doneAt[1], doneAt[2]);
    end
    tick();
  endtask

  task automatic test_exhaustive_w4();
    int lat;
    int full;
    logic [3:0] av, bv, expDiff;
    logic binv, expBout, expOvf;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          av = 4'(ai); bv = 4'(bi); binv = 1'(ci);
          full = ai - bi - ci;
          expDiff = 4'(full);
          expBout = (full < 0);
          expOvf = (av[3] != bv[3]) && (expDiff[3] != av[3]);
          run4(av, bv, binv, lat);
          nChecks++;
          if (lat !== 4 || bus4.diff !== expDiff || bus4.bout !== expBout || bus4.ovf !== expOvf) begin
            nFails++; $display("[TB] FAIL w4_%h_%h_%b: lat=%0d diff=%h bout=%b ovf=%b expected 4 %h %b %b", av, bv, binv, lat, bus4.diff, bus4.bout, bus4.ovf, expDiff, expBout, expOvf);
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_and_reset();
    test_back_to_back();
    test_exhaustive_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
